output_ctrl_rr: RTL and testbench

OUTPUT_CTRL_RR -- requirements
Module: output_ctrl_rr

---
 rtl/output_ctrl_rr.sv | 110 +++++++++++
 tb/tb_output_ctrl_rr.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/output_ctrl_rr.sv
// Round-robin merge of NUM_IN valid/ready inputs into a FIFO_DEPTH-entry output buffer.
// Optional per-input transfer counters on pkt_count when OUTPUT_CTRL_RR_STATS_EN is defined.
module output_ctrl_rr #(
  parameter int WIDTH_PACKET = 57,
  parameter int NUM_IN       = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN*WIDTH_PACKET-1:0] in_data,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           out_valid,
  output logic [WIDTH_PACKET-1:0]        out_data,
  input  logic                           out_ready,
  output logic [$clog2(FIFO_DEPTH):0]    occupancy
`ifdef OUTPUT_CTRL_RR_STATS_EN
  ,
  output logic [NUM_IN*16-1:0]           pkt_count
`endif
);

  localparam int PW = $clog2(NUM_IN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [WIDTH_PACKET-1:0] mem_q [FIFO_DEPTH];

  logic                    grant_vld;
  logic [PW-1:0]           grant_idx;
  logic [PW:0]             scan_idx;
  logic                    push, pop;
  logic [WIDTH_PACKET-1:0] push_dat;

  // Scan from rr_ptr downwards in priority so the nearest valid index is assigned last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NUM_IN))
        scan_idx = scan_idx - (PW+1)'(NUM_IN);
      if (in_valid[scan_idx[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[PW-1:0];
      end
    end
  end

  // A pop in the same cycle never frees a slot for a push while full.
  assign push      = rst_n && grant_vld && (count_q != CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign in_ready  = push ? (NUM_IN'(1) << grant_idx) : '0;
  assign push_dat  = in_data[grant_idx*WIDTH_PACKET +: WIDTH_PACKET];
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign occupancy = count_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push)
      rr_ptr_d = (grant_idx == PW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= push_dat;
  end

`ifdef OUTPUT_CTRL_RR_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_IN];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (!rst_n)
        pkt_cnt_q[i] <= '0;
      else if (in_ready[i] && in_valid[i] && (pkt_cnt_q[i] != 16'hFFFF))
        pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign pkt_count[g*16 +: 16] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_output_ctrl_rr.sv
// Directed bench for output_ctrl_rr at default parameters (57-bit packets, 4 inputs, depth 4).
module tb_output_ctrl_rr;
  localparam int W = 57;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [2:0]       occupancy;
`ifdef OUTPUT_CTRL_RR_STATS_EN
  logic [N*16-1:0]  pkt_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  output_ctrl_rr #(.WIDTH_PACKET(W), .NUM_IN(N), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef OUTPUT_CTRL_RR_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset held: no acceptance even with every input offering.
    in_valid = 4'b1111;
    settle();
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_occupancy", 64'(occupancy), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    tick();
    in_valid = '0;
    rst_n    = 1'b1;

    // Single packet on input 2.
    for (int i = 0; i < N; i++) set_lane(i, 57'h0DEAD0 + 57'(i));
    set_lane(2, 57'h1A5);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    settle();
    check("single_in_ready", 64'(in_ready), 64'h4);
    tick();
    in_valid = '0;
    settle();
    check("single_out_valid", 64'(out_valid), 64'h1);
    check("single_out_data", 64'(out_data), 64'h1A5);
    check("single_occupancy", 64'(occupancy), 64'h1);
    tick();
    settle();
    check("single_drained", 64'(out_valid), 64'h0);

    // Fairness from a fresh reset: all inputs valid.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_lane(i, 57'h100 + 57'(i));
    in_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      settle();
      check($sformatf("fair_grant_%0d", c), 64'(in_ready), 64'(1) << (c % 4));
      if (c > 0) begin
        check($sformatf("fair_data_%0d", c), 64'(out_data), 64'h100 + 64'((c - 1) % 4));
        check($sformatf("fair_occ_%0d", c), 64'(occupancy), 64'h1);
      end
      tick();
    end
    in_valid = '0;
    settle();
    check("fair_last_data", 64'(out_data), 64'h103);
    tick();
    settle();
    check("fair_empty", 64'(occupancy), 64'h0);

    // Backpressure: fill from input 0 while the head stays put.
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 57'h200 + 57'(k));
      settle();
      check($sformatf("bp_accept_%0d", k), 64'(in_ready), 64'h1);
      if (k > 0) check($sformatf("bp_head_stable_%0d", k), 64'(out_data), 64'h200);
      tick();
    end
    set_lane(0, 57'h2FF);
    settle();
    check("bp_full_occ", 64'(occupancy), 64'h4);
    check("bp_full_ready", 64'(in_ready), 64'h0);
    tick();
    check("bp_full_hold_head", 64'(out_data), 64'h200);

    // Full with a simultaneous pop: accept deferred one cycle.
    out_ready = 1'b1;
    settle();
    check("fullpop_ready", 64'(in_ready), 64'h0);
    tick();
    settle();
    check("fullpop_next_ready", 64'(in_ready), 64'h1);
    check("fullpop_next_occ", 64'(occupancy), 64'h3);
    check("fullpop_next_head", 64'(out_data), 64'h201);
    tick();
    in_valid = '0;
    begin
      logic [W-1:0] exp_d [3];
      exp_d[0] = 57'h202;
      exp_d[1] = 57'h203;
      exp_d[2] = 57'h2FF;
      for (int k = 0; k < 3; k++) begin
        settle();
        check($sformatf("drain_data_%0d", k), 64'(out_data), 64'(exp_d[k]));
        check($sformatf("drain_occ_%0d", k), 64'(occupancy), 64'(3 - k));
        tick();
      end
    end
    settle();
    check("drain_occ_end", 64'(occupancy), 64'h0);
    check("drain_valid_end", 64'(out_valid), 64'h0);

    // Mid-operation reset with three buffered packets and rr_ptr left at 2.
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_lane(1, 57'h333);
    for (int k = 0; k < 3; k++) tick();
    in_valid = '0;
    settle();
    check("midrst_pre_occ", 64'(occupancy), 64'h3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_occ", 64'(occupancy), 64'h0);
    in_valid = 4'b1010;
    settle();
    check("midrst_first_grant", 64'(in_ready), 64'h2);
    tick();
    in_valid = '0;
    settle();
    check("midrst_first_data", 64'(out_data), 64'h333);

`ifdef OUTPUT_CTRL_RR_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("stats_clear", 64'(pkt_count), 64'h0);
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    for (int k = 0; k < 70000; k++) tick();
    in_valid = '0;
    settle();
    check("stats_sat_in1", 64'(pkt_count[31:16]), 64'hFFFF);
    check("stats_others", 64'({pkt_count[63:32], pkt_count[15:0]}), 64'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("stats_reset", 64'(pkt_count), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
